// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl
// Sponge sequencer for the SHA3 core. It accepts AXI-stream message beats and
// maps each beat to a word index of the rate portion of the state. After TLAST
// it emits the SHA3 padding words. After every full rate block it runs
// ROUNDS permutation rounds. It then holds the digest until the consumer
// accepts it.
//
// Ports:
//   ACLK, ARESETn         clock, asynchronous active-low reset
//   TVALID/TREADY/TLAST   stream handshake and end of message
//   TID[1:0]              mode (0..3 = SHA3-224/256/384/512), taken on first beat
//   data_in               beat payload
//   absorb_valid/_idx/_data  XOR absorb_data into state word absorb_idx
//   round_en, round_idx   one permutation round and its constant index
//   digest_valid/digest_ready  digest hold / accept handshake
//   state_clr             zero the state register on this edge
//   digest_mode           latched mode of the current message
//   blk_cnt[15:0]         completed-permutation count, only with the
//                         SHA3_CTRL_BLKCNT_EN macro defined
module sha3_sponge_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ROUNDS     = 24
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  TVALID,
  output logic                  TREADY,
  input  logic                  TLAST,
  input  logic [1:0]            TID,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  absorb_valid,
  output logic [7:0]            absorb_idx,
  output logic [DATA_WIDTH-1:0] absorb_data,
  output logic                  round_en,
  output logic [4:0]            round_idx,
  output logic                  digest_valid,
  input  logic                  digest_ready,
  output logic                  state_clr,
`ifdef SHA3_CTRL_BLKCNT_EN
  output logic [15:0]           blk_cnt,
`endif
  output logic [1:0]            digest_mode
);

  typedef enum logic [1:0] {S_ABSORB, S_PAD, S_PERMUTE, S_DONE} state_e;

  // Rate expressed in absorb words for each mode.
  function automatic logic [7:0] rate_words(input logic [1:0] mode);
    unique case (mode)
      2'd0:    return 8'(1152 / DATA_WIDTH);
      2'd1:    return 8'(1088 / DATA_WIDTH);
      2'd2:    return 8'(832 / DATA_WIDTH);
      default: return 8'(576 / DATA_WIDTH);
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pad_idx_q, pad_idx_d;
  logic [4:0] round_q, round_d;
  logic       pad_first_q, pad_first_d;
  logic       pad_pending_q, pad_pending_d;
  logic       final_q, final_d;
  logic       mode_latched_q, mode_latched_d;
  logic [1:0] mode_q, mode_d;
`ifdef SHA3_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;
`endif

  logic       beat;
  logic [1:0] active_mode;
  logic [7:0] r_last;
  logic       round_last;

  // The first beat of a message sizes its block with the live TID, because
  // the latch only takes effect on the following edge.
  assign active_mode = mode_latched_q ? mode_q : TID;
  assign r_last      = 8'(rate_words(active_mode) - 8'd1);
  assign round_last  = (round_q == 5'(ROUNDS - 1));
  // TREADY is gated by ARESETn so that it reads 0 while reset is asserted,
  // even though the reset state is ABSORB.
  assign TREADY      = ARESETn && (state_q == S_ABSORB);
  assign beat        = TREADY && TVALID;
  assign round_idx   = round_q;
  assign digest_mode = mode_q;
`ifdef SHA3_CTRL_BLKCNT_EN
  assign blk_cnt     = blk_cnt_q;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q        <= S_ABSORB;
      cnt_q          <= '0;
      pad_idx_q      <= '0;
      round_q        <= '0;
      pad_first_q    <= 1'b0;
      pad_pending_q  <= 1'b0;
      final_q        <= 1'b0;
      mode_latched_q <= 1'b0;
      mode_q         <= '0;
`ifdef SHA3_CTRL_BLKCNT_EN
      blk_cnt_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, so ordering inside this block does not matter.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pad_idx_q      <= pad_idx_d;
      round_q        <= round_d;
      pad_first_q    <= pad_first_d;
      pad_pending_q  <= pad_pending_d;
      final_q        <= final_d;
      mode_latched_q <= mode_latched_d;
      mode_q         <= mode_d;
`ifdef SHA3_CTRL_BLKCNT_EN
      blk_cnt_q      <= blk_cnt_d;
`endif
    end
  end

  // Next-state and datapath-register logic.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d        = state_q;
    cnt_d          = cnt_q;
    pad_idx_d      = pad_idx_q;
    round_d        = round_q;
    pad_first_d    = pad_first_q;
    pad_pending_d  = pad_pending_q;
    final_d        = final_q;
    mode_latched_d = mode_latched_q;
    mode_d         = mode_q;
`ifdef SHA3_CTRL_BLKCNT_EN
    blk_cnt_d      = blk_cnt_q;
`endif
    unique case (state_q)
      S_ABSORB: begin
        if (beat) begin
          if (!mode_latched_q) begin
            mode_d         = TID;
            mode_latched_d = 1'b1;
          end
          if (cnt_q == r_last) begin
            // A full block with TLAST still needs a whole block of padding.
            cnt_d         = '0;
            pad_pending_d = TLAST;
            state_d       = S_PERMUTE;
          end else begin
            cnt_d = 8'(cnt_q + 8'd1);
            if (TLAST) begin
              pad_idx_d   = 8'(cnt_q + 8'd1);
              pad_first_d = 1'b1;
              state_d     = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        pad_first_d = 1'b0;
        pad_idx_d   = 8'(pad_idx_q + 8'd1);
        if (pad_idx_q == r_last) begin
          final_d = 1'b1;
          state_d = S_PERMUTE;
        end
      end
      S_PERMUTE: begin
        if (round_last) begin
          round_d = '0;
`ifdef SHA3_CTRL_BLKCNT_EN
          if (blk_cnt_q != 16'hFFFF) blk_cnt_d = blk_cnt_q + 16'd1;
`endif
          if (final_q) begin
            state_d = S_DONE;
          end else if (pad_pending_q) begin
            pad_pending_d = 1'b0;
            pad_idx_d     = '0;
            pad_first_d   = 1'b1;
            state_d       = S_PAD;
          end else begin
            state_d = S_ABSORB;
          end
        end else begin
          round_d = 5'(round_q + 5'd1);
        end
      end
      default: begin  // S_DONE
        if (digest_ready) begin
          cnt_d          = '0;
          final_d        = 1'b0;
          pad_pending_d  = 1'b0;
          mode_latched_d = 1'b0;
          state_d        = S_ABSORB;
        end
      end
    endcase
  end

  // Output decode.
  always_comb begin
    absorb_valid = 1'b0;
    absorb_idx   = '0;
    absorb_data  = '0;
    round_en     = 1'b0;
    digest_valid = 1'b0;
    state_clr    = 1'b0;
    unique case (state_q)
      S_ABSORB: begin
        if (beat) begin
          absorb_valid = 1'b1;
          absorb_idx   = cnt_q;
          absorb_data  = data_in;
        end
      end
      S_PAD: begin
        absorb_valid = 1'b1;
        absorb_idx   = pad_idx_q;
        // The first and last pad words may coincide and then carry both bytes.
        if (pad_first_q) absorb_data[7:0] = 8'h06;
        if (pad_idx_q == r_last) absorb_data[DATA_WIDTH-1 -: 8] = 8'h80;
      end
      S_PERMUTE: round_en = 1'b1;
      default: begin  // S_DONE
        digest_valid = 1'b1;
        state_clr    = digest_ready;
      end
    endcase
  end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Testbench for sha3_sponge_ctrl. A message-level model turns each message into
// the ordered list of strobes the core must produce: beats, pad words, rounds
// and the digest hold. A single compare process walks that list cycle by cycle.
module tb_sha3_sponge_ctrl;
  localparam int DW     = 64;
  localparam int ROUNDS = 24;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          TVALID = 1'b0;
  logic          TLAST = 1'b0;
  logic [1:0]    TID = 2'd0;
  logic [DW-1:0] data_in = '0;
  logic          digest_ready;
  logic          TREADY, absorb_valid, round_en, digest_valid, state_clr;
  logic [7:0]    absorb_idx;
  logic [DW-1:0] absorb_data;
  logic [4:0]    round_idx;
  logic [1:0]    digest_mode;
`ifdef SHA3_CTRL_BLKCNT_EN
  logic [15:0]   blk_cnt;
`endif

  sha3_sponge_ctrl #(.DATA_WIDTH(DW), .ROUNDS(ROUNDS)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(TREADY),
    .TLAST(TLAST), .TID(TID), .data_in(data_in),
    .absorb_valid(absorb_valid), .absorb_idx(absorb_idx), .absorb_data(absorb_data),
    .round_en(round_en), .round_idx(round_idx),
    .digest_valid(digest_valid), .digest_ready(digest_ready),
    .state_clr(state_clr),
`ifdef SHA3_CTRL_BLKCNT_EN
    .blk_cnt(blk_cnt),
`endif
    .digest_mode(digest_mode)
  );

  always #5 ACLK = ~ACLK;

  typedef enum int {EV_BEAT, EV_PAD, EV_ROUND, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e      kind;
    logic [7:0]    idx;
    logic [DW-1:0] data;
    logic [1:0]    mode;
  } ev_t;

  ev_t q[$];       // expected strobes; appended by the stimulus only
  int  rp = 0;     // read pointer; advanced by the compare process only
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  clr_cnt = 0;
  bit  dr_rand = 1'b1;
  bit  dr_force = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rate_w(input logic [1:0] m);
    int rb[4] = '{1152, 1088, 832, 576};
    return rb[m] / DW;
  endfunction

  // Message model: the strobe list a message of n words must produce.
  task automatic build(input logic [1:0] m, input logic [DW-1:0] w[$], output ev_t evs[$]);
    int  r = rate_w(m);
    int  n = w.size();
    int  s;
    ev_t e;
    evs = {};
    for (int i = 0; i < n; i++) begin
      e = '{EV_BEAT, 8'(i % r), w[i], 2'd0};
      evs.push_back(e);
      if (i % r == r - 1)
        for (int k = 0; k < ROUNDS; k++) begin
          e = '{EV_ROUND, 8'(k), '0, 2'd0};
          evs.push_back(e);
        end
    end
    s = n % r;
    for (int j = s; j < r; j++) begin
      e = '{EV_PAD, 8'(j), '0, 2'd0};
      if (j == s) e.data[7:0] = 8'h06;
      if (j == r - 1) e.data[DW-1 -: 8] = 8'h80;
      evs.push_back(e);
    end
    for (int k = 0; k < ROUNDS; k++) begin
      e = '{EV_ROUND, 8'(k), '0, 2'd0};
      evs.push_back(e);
    end
    e = '{EV_DONE, 8'd0, '0, m};
    evs.push_back(e);
  endtask

  // digest_ready source: random, or forced by the main sequence.
  initial begin
    digest_ready = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      digest_ready = dr_rand ? ($urandom_range(0, 3) == 0) : dr_force;
    end
  end

  // Compare process: every cycle out of reset, the front of the expected list
  // dictates what the outputs must be.
  initial begin
    ev_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        rp = q.size();
      end else begin
        check("exclusive_strobes", 64'(absorb_valid & round_en), 64'd0);
        if (state_clr) clr_cnt++;
        if (rp >= q.size()) begin
          check("idle_tready", 64'(TREADY), 64'd1);
          check("idle_strobes", 64'({absorb_valid, round_en, digest_valid, state_clr}), 64'd0);
        end else begin
          e = q[rp];
          case (e.kind)
            EV_BEAT: begin
              check("beat_tready", 64'(TREADY), 64'd1);
              check("beat_av", 64'(absorb_valid), 64'(TVALID));
              check("beat_others", 64'({round_en, digest_valid, state_clr}), 64'd0);
              if (absorb_valid) begin
                check("beat_idx", 64'(absorb_idx), 64'(e.idx));
                check("beat_data", absorb_data, e.data);
                rp++;
              end else begin
                check("idle_idx", 64'(absorb_idx), 64'd0);
                check("idle_data", absorb_data, 64'd0);
              end
            end
            EV_PAD: begin
              check("pad_tready", 64'(TREADY), 64'd0);
              check("pad_av", 64'(absorb_valid), 64'd1);
              check("pad_idx", 64'(absorb_idx), 64'(e.idx));
              check("pad_data", absorb_data, e.data);
              check("pad_others", 64'({round_en, digest_valid}), 64'd0);
              rp++;
            end
            EV_ROUND: begin
              check("round_tready", 64'(TREADY), 64'd0);
              check("round_en", 64'(round_en), 64'd1);
              check("round_idx", 64'(round_idx), 64'(e.idx));
              check("round_others", 64'({absorb_valid, digest_valid}), 64'd0);
              rp++;
            end
            default: begin
              check("done_tready", 64'(TREADY), 64'd0);
              check("done_valid", 64'(digest_valid), 64'd1);
              check("done_mode", 64'(digest_mode), 64'(e.mode));
              check("done_clr", 64'(state_clr), 64'(digest_ready));
              check("done_others", 64'({absorb_valid, round_en}), 64'd0);
              if (digest_ready) rp++;
            end
          endcase
        end
      end
    end
  end

  // Drives one message; TVALID is left high so back-to-back calls keep it
  // asserted. Entered and left at posedge+1.
  task automatic send_msg(input logic [1:0] m, input int n, input int max_gap, output int acc_cyc);
    logic [DW-1:0] w[$];
    ev_t           evs[$];
    bit            ok;
    int            gap;
    acc_cyc = 0;
    for (int i = 0; i < n; i++) w.push_back({$urandom, $urandom});
    build(m, w, evs);
    foreach (evs[i]) q.push_back(evs[i]);
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (gap > 0) begin
        TVALID = 1'b0;
        repeat (gap) begin @(posedge ACLK); #1; end
      end
      TVALID  = 1'b1;
      data_in = w[i];
      TLAST   = (i == n - 1);
      TID     = (i == 0) ? m : 2'($urandom_range(0, 3));
      ok = 1'b0;
      for (int t = 0; t < 500 && !ok; t++) begin
        @(negedge ACLK);
        ok = TREADY;
      end
      if (!ok) begin
        check("beat_accept_timeout", 64'd0, 64'd1);
        TVALID = 1'b0;
        return;
      end
      if (i == 0) acc_cyc = cyc;
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic idle_src();
    TVALID = 1'b0;
    TLAST  = 1'b0;
  endtask

  task automatic wait_dv(output int c);
    bit ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge ACLK);
      ok = digest_valid;
    end
    c = cyc;
    if (!ok) check("digest_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 5000 && rp < q.size(); t++) @(negedge ACLK);
    if (rp < q.size()) check("drain_timeout", 64'(q.size() - rp), 64'd0);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ev_t           evs[$];
    logic [DW-1:0] w[$];
    int            acc, dv, clr0;
    bit            ok;

    // Reset: all strobes low even with a beat offered.
    TVALID = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tready", 64'(TREADY), 64'd0);
    check("rst_strobes", 64'({absorb_valid, round_en, digest_valid, state_clr}), 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    check("rst_mode", 64'(digest_mode), 64'd0);
    check("rst_bus", 64'(absorb_idx) | absorb_data, 64'd0);
    TVALID = 1'b0;
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    check("post_rst_tready", 64'(TREADY), 64'd1);

    // Hand-computed pins on the message model.
    w = '{64'hA5};
    build(2'd1, w, evs);
    check("pin1_len", 64'(evs.size()), 64'd42);
    check("pin1_pad_first", evs[1].data, 64'h06);
    check("pin1_pad_last", evs[16].data, 64'h8000_0000_0000_0000);
    check("pin1_pad_last_idx", 64'(evs[16].idx), 64'd16);
    check("pin1_round0", 64'(evs[17].kind), 64'(EV_ROUND));
    check("pin1_done", 64'(evs[41].kind), 64'(EV_DONE));
    w = {};
    for (int i = 0; i < 9; i++) w.push_back(64'(i));
    build(2'd3, w, evs);
    check("pin2_len", 64'(evs.size()), 64'd67);
    check("pin2_round_after_idx8", 64'(evs[9].kind), 64'(EV_ROUND));
    check("pin2_pad0", {56'(evs[33].idx), evs[33].data[7:0]}, 64'h06);
    check("pin2_pad8", evs[41].data, 64'h8000_0000_0000_0000);
    w = {};
    for (int i = 0; i < 24; i++) w.push_back(64'(i));
    build(2'd0, w, evs);
    check("pin3_len", 64'(evs.size()), 64'd85);
    check("pin3_beat18_idx", 64'(evs[42].idx), 64'd0);
    check("pin3_beat23_idx", 64'(evs[47].idx), 64'd5);
    check("pin3_pad_start", {56'(evs[48].idx), evs[48].data[7:0]}, 64'h0606);

    // Scenario 1: one beat, TID=1, digest taken at once.
    dr_rand = 1'b0; dr_force = 1'b1;
    send_msg(2'd1, 1, 0, acc);
    idle_src();
    wait_dv(dv);
    check("s1_latency", 64'(dv - acc), 64'd41);
    wait_drain();

    // Scenario 2: nine beats, TID=3, padding-only block after the data.
    send_msg(2'd3, 9, 0, acc);
    idle_src();
    wait_drain();
`ifdef SHA3_CTRL_BLKCNT_EN
    check("blk_cnt_3", 64'(blk_cnt), 64'd3);
`endif

    // Scenario 3: 24 beats, TID=0; later TID values are randomised.
    send_msg(2'd0, 24, 0, acc);
    idle_src();
    wait_drain();

    // Backpressure: TVALID held high across messages, random digest_ready.
    dr_rand = 1'b1;
    send_msg(2'd2, 5, 0, acc);
    send_msg(2'd1, 17, 0, acc);
    send_msg(2'd3, 18, 0, acc);
    idle_src();
    wait_drain();

    // Digest held for 10 cycles, then accepted exactly once.
    dr_rand = 1'b0; dr_force = 1'b0;
    clr0 = clr_cnt;
    send_msg(2'd1, 3, 0, acc);
    idle_src();
    wait_dv(dv);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check("hold_digest_valid", 64'(digest_valid), 64'd1);
    end
    dr_force = 1'b1;
    @(negedge ACLK);
    dr_force = 1'b0;
    repeat (3) @(negedge ACLK);
    check("state_clr_once", 64'(clr_cnt - clr0), 64'd1);
    wait_drain();

    // Reset during permutation round 7.
    dr_rand = 1'b1;
    send_msg(2'd1, 1, 0, acc);
    idle_src();
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge ACLK);
      ok = round_en && (round_idx == 5'd7);
    end
    if (!ok) check("round7_timeout", 64'd0, 64'd1);
    #1 ARESETn = 1'b0;
    #1;
    check("abort_strobes", 64'({TREADY, absorb_valid, round_en, digest_valid, state_clr}), 64'd0);
    check("abort_round_idx", 64'(round_idx), 64'd0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    check("rerst_tready", 64'(TREADY), 64'd1);
    check("rerst_bus", 64'(absorb_idx) | absorb_data, 64'd0);
    @(posedge ACLK);
    #1;
    dr_rand = 1'b0; dr_force = 1'b1;
    send_msg(2'd1, 1, 0, acc);
    idle_src();
    wait_dv(dv);
    check("s1_again_latency", 64'(dv - acc), 64'd41);
    wait_drain();

    // Randomised messages with idle gaps and random digest acceptance.
    dr_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      send_msg(2'($urandom_range(0, 3)), $urandom_range(1, 40), 2, acc);
      if ($urandom_range(0, 1) == 0) idle_src();
    end
    idle_src();
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
